mobius_inv_iter: RTL and testbench
==================================

Name: mobius_inv_iter

Overview:
- Iterative, area-compact Möbius transform engine over GF(2). It converts an N-bit truth table into its ANF coefficient vector, which is the reverse direction of the combinational expmob1 path.
- The transform is an involution, so the same block also maps ANF back to a truth table.
- It reuses one runtime-selectable butterfly stage for LOG2_N clock cycles instead of instantiating LOG2_N stages. Stages are applied in reverse order, from the last stage down to stage 0; this is legal because the stages commute.
- It sits between a truth-table producer and the ANF consumer, with valid/ready on both sides.

Parameters:
- N, 32, transform width in bits; must be a power of two, N >= 2.
- LOG2_N, 5, log2(N); number of butterfly stages and number of RUN cycles.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector; high only in IDLE.
- in_data  input  [0:N-1]  truth table; index 0 is the MSB and corresponds to input point 0.
- out_valid  output  1  out_data holds a finished transform.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  [0:N-1]  ANF coefficients, same index convention as in_data.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, data register=0, stage counter=LOG2_N-1.
  - in_ready=1, out_valid=0, busy=0, out_data=0.
- States and transitions:
  - IDLE -> RUN on an in_valid&&in_ready edge. At that edge: data register <= in_data, stage counter <= LOG2_N-1.
  - RUN: each edge, data register <= stage(counter)(data register).
    - counter>0: counter decrements, state stays RUN.
    - counter==0: state -> DONE, counter reloads to LOG2_N-1.
  - DONE: out_valid=1, data register held stable.
    - On out_valid&&out_ready -> IDLE.
    - While out_ready=0, out_data and out_valid are held (no change).
- Stage s, with half=N>>(s+1):
  - For each index i whose bit (LOG2_N-1-s) is 1 (MSB-first index): next[i] = cur[i] ^ cur[i-half].
  - All other bits pass unchanged.
  - Pure XOR; no carries or width growth.
- Latency and throughput:
  - out_valid rises exactly LOG2_N cycles after the accept edge.
  - No input is accepted in the same cycle as the output handshake, because in_ready is low in DONE.
  - Throughput is therefore one vector per LOG2_N+2 cycles minimum.
- out_data is driven directly from the data register in every state, and is only meaningful when out_valid=1.
- in_valid while not in IDLE is ignored, and in_data is not sampled.
- in_data may change freely when in_ready=0.
- rst asserted mid-RUN or in DONE: the operation is aborted immediately, all outputs return to their reset values, and the pending result is discarded.
- Back-to-back operation: the producer holding in_valid=1 is accepted on the first IDLE cycle after the output handshake.

Decomposition:
- Shared package mobius_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default N and LOG2_N;
  - a function returning half-width for stage s, shared with expmob1 users.
- One sub-module, mobius_stage_sel:
  - combinational, parameters N and LOG2_N;
  - inputs data[0:N-1] and sel[$clog2(LOG2_N)-1:0];
  - output data[0:N-1] equal to stage(sel) applied to the input.
  - It is unit-testable against expmob1's fixed stage.

Test Plan (N=32, LOG2_N=5):
1. Basic transform, single-bit inputs:
   - in_data=32'h80000000 (only index 0) -> after 5 cycles, out_valid=1, out_data=32'hFFFFFFFF.
   - in_data=32'h00000001 -> out_data=32'h00000001.
2. Constant function: in_data=32'hFFFFFFFF -> out_data=32'h80000000.
3. Involution: feed 32'hDEADBEEF, capture the result R, then feed R -> second out_data=32'hDEADBEEF. Every result must also match a combinational expmob1 reference model for 1000 random vectors.
4. Backpressure: out_ready=0 for 10 cycles after out_valid rises -> out_data is stable, out_valid stays 1, and in_ready stays 0 even with in_valid=1.
   - Then raise out_ready for 1 cycle -> IDLE next cycle, in_ready=1.
5. Reset mid-operation: assert rst asynchronously 2 cycles into RUN -> out_valid=0, busy=0, in_ready=1 and out_data=0 immediately (before the next edge).
   - A subsequent vector 32'h80000000 still yields 32'hFFFFFFFF.
6. Streaming: in_valid held high with 4 queued vectors and out_ready=1 -> exactly 4 results, each 7 cycles apart, all matching the reference model, and no vector dropped or duplicated.

Source files
------------

// File: rtl/mobius_pkg.sv
// Shared definitions for the GF(2) Moebius transform blocks: controller states,
// default sizing and the per-stage butterfly span.
package mobius_pkg;

  localparam int DEFAULT_N      = 32;
  localparam int DEFAULT_LOG2_N = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mobius_state_t;

  // Distance between the two bits combined by stage s (MSB-first indexing).
  function automatic int stage_half(input int n, input int s);
    return n >> (s + 1);
  endfunction

  // Width of a stage selector; kept at one bit for the degenerate N=2 case.
  function automatic int sel_width(input int log2_n);
    return (log2_n > 1) ? $clog2(log2_n) : 1;
  endfunction

endpackage : mobius_pkg

// File: rtl/mobius_stage_sel.sv
// One Moebius butterfly stage over GF(2), chosen at runtime by sel.
// Index 0 is the MSB of the vector and stands for input point 0.
module mobius_stage_sel
  import mobius_pkg::*;
#(
  parameter  int N      = DEFAULT_N,
  parameter  int LOG2_N = DEFAULT_LOG2_N,
  localparam int SW     = sel_width(LOG2_N)
) (
  input  logic [0:N-1]  data,
  input  logic [SW-1:0] sel,
  output logic [0:N-1]  result
);

  always_comb begin
    // NOTE: default assignment first, so every path drives result and no latch is inferred.
    result = data;
    for (int s = 0; s < LOG2_N; s++) begin
      if (sel == SW'(s)) begin
        for (int i = 0; i < N; i++) begin
          // With that index bit set, i ^ half is the same as i - half.
          if (((i >> (LOG2_N - 1 - s)) & 1) == 1) begin
            result[i] = data[i] ^ data[i ^ stage_half(N, s)];
          end
        end
      end
    end
  end

endmodule : mobius_stage_sel

// File: rtl/mobius_inv_iter.sv
// Iterative truth-table -> ANF transform: one shared butterfly stage applied
// LOG2_N times, last stage first, with valid/ready on both sides.
module mobius_inv_iter
  import mobius_pkg::*;
#(
  parameter  int N      = DEFAULT_N,
  parameter  int LOG2_N = DEFAULT_LOG2_N,
  localparam int SW     = sel_width(LOG2_N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:N-1] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:N-1] out_data,
  output logic         busy
);

  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2_N - 1);

  mobius_state_t state_q, state_d;
  logic [0:N-1]  data_q;
  logic [0:N-1]  stage_out;
  logic [SW-1:0] stage_q;

  mobius_stage_sel #(
    .N      (N),
    .LOG2_N (LOG2_N)
  ) u_stage (
    .data   (data_q),
    .sel    (stage_q),
    .result (stage_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)       state_d = RUN;
      RUN:     if (stage_q == '0)  state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    out_data  = data_q;
  end

  // Data register and stage counter; held untouched in DONE so backpressure is free.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: data_q is reset because out_data is visible in every state, including after an abort.
    if (rst) begin
      data_q  <= '0;
      stage_q <= LAST_STAGE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            stage_q <= LAST_STAGE;
          end
        end
        RUN: begin
          data_q <= stage_out;
          if (stage_q == '0) stage_q <= LAST_STAGE;
          else               stage_q <= stage_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule : mobius_inv_iter

// File: tb/tb_mobius_inv_iter.sv
// Self-checking bench for mobius_inv_iter: constant vectors, random vectors
// against a subset-sum ANF model, backpressure, abort by reset and streaming.
module tb_mobius_inv_iter;

  localparam int N      = 32;
  localparam int LOG2_N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:N-1] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:N-1] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  mobius_inv_iter #(.N(N), .LOG2_N(LOG2_N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [0:N-1] din;
    logic [0:N-1] expect_out;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ANF coefficient i is the XOR of f over every point j whose set bits lie within i.
  function automatic logic [0:N-1] anf_model(input logic [0:N-1] f);
    logic [0:N-1] r;
    logic         acc;
    for (int i = 0; i < N; i++) begin
      acc = 1'b0;
      for (int j = 0; j < N; j++)
        if ((j & ~i) == 0) acc ^= f[j];
      r[i] = acc;
    end
    return r;
  endfunction

  // Present one vector, wait (bounded) for the result, return it and the latency.
  task automatic transform(input logic [0:N-1] din, output logic [0:N-1] dout, output int lat);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = din;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    dout = out_data;
  endtask

  vec_t         vecs[4];
  logic [0:N-1] r, r2, held, expv;
  int           lat;
  logic [0:N-1] sv[4];
  logic [0:N-1] res[8];
  int           rcyc[8];
  int           nres, k, cyc;

  initial begin
    vecs[0] = '{"single_idx0", 32'h80000000, 32'hFFFFFFFF};
    vecs[1] = '{"single_idx31", 32'h00000001, 32'h00000001};
    vecs[2] = '{"constant_one", 32'hFFFFFFFF, 32'h80000000};
    vecs[3] = '{"zero", 32'h00000000, 32'h00000000};

    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    #2;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_data", out_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven known vectors, with latency and busy/in_ready status.
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[v].din;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check({vecs[v].name, "_run_status"}, {30'd0, busy, in_ready}, 32'b10);
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check({vecs[v].name, "_latency"}, lat, LOG2_N);
      check(vecs[v].name, out_data, vecs[v].expect_out);
      @(negedge clk);
      check({vecs[v].name, "_back_idle"}, 32'(in_ready), 32'd1);
    end

    // Involution.
    transform(32'hDEADBEEF, r, lat);
    check("invol_first", r, anf_model(32'hDEADBEEF));
    transform(r, r2, lat);
    check("invol_second", r2, 32'hDEADBEEF);

    // Random vectors against the model.
    for (int n = 0; n < 1000; n++) begin
      logic [0:N-1] d;
      d = $urandom;
      transform(d, r, lat);
      check("rand_latency", lat, LOG2_N);
      check("rand_data", r, anf_model(d));
    end

    // Backpressure: result held, new input refused.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0F0F1234;
    expv      = anf_model(32'h0F0F1234);
    @(negedge clk);
    in_data = 32'hA5A5A5A5;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, LOG2_N);
    held = out_data;
    check("bp_data", held, expv);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, held);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Abort by reset two cycles into RUN.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'h12345678;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_data", out_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    transform(32'h80000000, r, lat);
    check("after_abort_latency", lat, LOG2_N);
    check("after_abort_data", r, 32'hFFFFFFFF);

    // Streaming with in_valid held high.
    for (int i = 0; i < 4; i++) sv[i] = $urandom;
    @(negedge clk);
    out_ready = 1'b1;
    nres = 0;
    k    = 0;
    cyc  = 0;
    for (int t = 0; t < 60; t++) begin
      if (t > 0) @(negedge clk);
      cyc++;
      if (out_valid && nres < 8) begin
        res[nres]  = out_data;
        rcyc[nres] = cyc;
        nres++;
      end
      if (k < 4) begin
        in_valid = 1'b1;
        in_data  = sv[k];
        if (in_ready) k++;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("stream_count", nres, 4);
    for (int i = 0; i < 4 && i < nres; i++) begin
      check("stream_data", res[i], anf_model(sv[i]));
      if (i > 0) check("stream_spacing", rcyc[i] - rcyc[i-1], LOG2_N + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mobius_inv_iter
